// File: rtl/ddr2_pkg.sv
// Shared DDR2 command encodings, violation codes and init-sequence states
// used by the command monitor and the initializer.
package ddr2_pkg;

  // {RAS,CAS,WE} as seen on the pins
  typedef enum logic [2:0] {
    MRST = 3'b000,
    ARSR = 3'b001,
    PRCH = 3'b010,
    ACTV = 3'b011,
    WRTE = 3'b100,
    READ = 3'b101,
    BTRM = 3'b110,
    NOOP = 3'b111
  } cmd_e;

  localparam logic [3:0] ERR_NONE   = 4'd0;
  localparam logic [3:0] ERR_SEQ    = 4'd1;
  localparam logic [3:0] ERR_TMRD   = 4'd2;
  localparam logic [3:0] ERR_TRP    = 4'd3;
  localparam logic [3:0] ERR_TRFC   = 4'd4;
  localparam logic [3:0] ERR_TRCD   = 4'd5;
  localparam logic [3:0] ERR_CLOSED = 4'd6;
  localparam logic [3:0] ERR_OPEN   = 4'd7;
  localparam logic [3:0] ERR_CKE    = 4'd8;
  localparam logic [3:0] ERR_NOINIT = 4'd9;

  typedef enum logic [3:0] {
    S_CKE, S_PRE1, S_EMR2, S_EMR3, S_EMR, S_MRDLL,
    S_PRE2, S_REF1, S_REF2, S_MR, S_OCD, S_DONE
  } init_state_e;

  // The counter reads 0 on the cycle after its initiating command, so the
  // elapsed cycle count at a later command is cnt+1.
  function automatic logic too_soon(input logic [4:0] cnt, input int unsigned lim);
    return (32'(cnt) + 32'd1) < lim;
  endfunction

endpackage

// File: rtl/ddr2_cmd_monitor_if.sv
// Pin-side DDR2 command bus: the controller drives it, the monitor listens.
interface ddr2_cmd_monitor_if;
  logic        CKE;
  logic [2:0]  COMMAND_PIN;
  logic [13:0] ADDRESS_PIN;
  logic [2:0]  BANK_PIN;

  modport master (output CKE, output COMMAND_PIN, output ADDRESS_PIN, output BANK_PIN);
  modport slave  (input  CKE, input  COMMAND_PIN, input  ADDRESS_PIN, input  BANK_PIN);
endinterface

// File: rtl/ddr2_bank_tracker.sv
// Per-bank open-row bits plus the ACTV-to-READ/WRTE (tRCD) counters.
module ddr2_bank_tracker
  import ddr2_pkg::*;
#(
  parameter int unsigned T_RCD = 3
) (
  input  logic       CLK_n,
  input  logic       RST,
  input  logic       set_en,
  input  logic       clr_en,
  input  logic       clr_all,
  input  logic [2:0] bank,
  output logic [7:0] bank_open,
  output logic       rcd_early
);

  logic [7:0] open_q, open_d;
  logic [3:0] cnt_q [8];
  logic [3:0] cnt_d [8];

  always_comb begin
    open_d = open_q;
    if (clr_all) open_d = '0;
    if (clr_en)  open_d[bank] = 1'b0;
    if (set_en)  open_d[bank] = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + 4'd1;
      if (set_en && bank == 3'(i)) cnt_d[i] = '0;
    end
  end

  assign bank_open = open_q;
  assign rcd_early = too_soon({1'b0, cnt_q[bank]}, T_RCD);

  always_ff @(posedge CLK_n) begin
    if (!RST) begin
      open_q <= '0;
      cnt_q  <= '{default: '1};
    end else begin
      open_q <= open_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr2_cmd_monitor.sv
// Receive-side DDR2 command monitor: decodes pin commands, checks the power-up
// sequence and timing, shadows the mode registers and latches the first violation.
module ddr2_cmd_monitor
  import ddr2_pkg::*;
#(
  parameter int unsigned T_MRD = 2,
  parameter int unsigned T_RP  = 3,
  parameter int unsigned T_RFC = 16,
  parameter int unsigned T_RCD = 3
) (
  input  logic         CLK_n,
  input  logic         RST,
  ddr2_cmd_monitor_if.slave pins,
  output logic         CMD_STROBE,
  output logic [2:0]   CMD_CODE,
  output logic [13:0]  MR0,
  output logic [13:0]  MR1,
  output logic [13:0]  MR2,
  output logic [13:0]  MR3,
  output logic [7:0]   BANK_OPEN,
  output logic         INIT_DONE,
  output logic         ERROR,
  output logic [3:0]   ERR_CODE
);

  logic [2:0] cmd, bank;
  logic       a8, a10;
  logic       cmd_vld, is_mrst, is_arsr, is_prch, is_actv, is_rdwr;

  assign cmd     = pins.COMMAND_PIN;
  assign bank    = pins.BANK_PIN;
  assign a8      = pins.ADDRESS_PIN[8];
  assign a10     = pins.ADDRESS_PIN[10];
  assign cmd_vld = (cmd != NOOP);
  assign is_mrst = (cmd == MRST);
  assign is_arsr = (cmd == ARSR);
  assign is_prch = (cmd == PRCH);
  assign is_actv = (cmd == ACTV);
  assign is_rdwr = (cmd == READ) || (cmd == WRTE);

  init_state_e state_q, state_d;
  logic        seq_ok;
  logic [4:0]  cnt_mrd_q, cnt_mrd_d, cnt_rp_q, cnt_rp_d, cnt_rfc_q, cnt_rfc_d;
  logic        cmd_strobe_q, cmd_strobe_d;
  logic [2:0]  cmd_code_q, cmd_code_d;
  logic [13:0] mr_q [4];
  logic [13:0] mr_d [4];
  logic        err_q, err_d;
  logic [3:0]  err_code_q, err_code_d, new_code;
  logic        rcd_early;

  always_comb begin
    state_d = state_q;
    seq_ok  = 1'b1;
    if (state_q == S_CKE) begin
      if (pins.CKE) state_d = S_PRE1;
    end else if (cmd_vld && pins.CKE && state_q != S_DONE) begin
      seq_ok = 1'b0;
      case (state_q)
        S_PRE1:  if (is_prch && a10) begin state_d = S_EMR2; seq_ok = 1'b1; end
        S_EMR2:  if (is_mrst && bank == 3'd2) begin state_d = S_EMR3; seq_ok = 1'b1; end
        S_EMR3:  if (is_mrst && bank == 3'd3) begin state_d = S_EMR; seq_ok = 1'b1; end
        S_EMR:   if (is_mrst && bank == 3'd1) begin state_d = S_MRDLL; seq_ok = 1'b1; end
        S_MRDLL: if (is_mrst && bank == 3'd0 && a8) begin state_d = S_PRE2; seq_ok = 1'b1; end
        S_PRE2:  if (is_prch && a10) begin state_d = S_REF1; seq_ok = 1'b1; end
        S_REF1:  if (is_arsr) begin state_d = S_REF2; seq_ok = 1'b1; end
        S_REF2:  if (is_arsr) begin state_d = S_MR; seq_ok = 1'b1; end
        S_MR: begin
          if (is_arsr) seq_ok = 1'b1;
          else if (is_mrst && bank == 3'd0 && !a8) begin state_d = S_OCD; seq_ok = 1'b1; end
        end
        S_OCD: begin
          if (is_mrst && bank == 3'd1 && pins.ADDRESS_PIN[9:7] == 3'b111) seq_ok = 1'b1;
          else if (is_mrst && bank == 3'd1 && pins.ADDRESS_PIN[9:7] == 3'b000) begin
            state_d = S_DONE;
            seq_ok  = 1'b1;
          end
        end
        default: seq_ok = 1'b1;
      endcase
    end
  end

  always_comb begin
    cnt_mrd_d = (cnt_mrd_q == '1) ? cnt_mrd_q : cnt_mrd_q + 5'd1;
    cnt_rp_d  = (cnt_rp_q  == '1) ? cnt_rp_q  : cnt_rp_q  + 5'd1;
    cnt_rfc_d = (cnt_rfc_q == '1) ? cnt_rfc_q : cnt_rfc_q + 5'd1;
    if (is_mrst) cnt_mrd_d = '0;
    if (is_prch) cnt_rp_d  = '0;
    if (is_arsr) cnt_rfc_d = '0;

    cmd_strobe_d = cmd_vld;
    cmd_code_d   = cmd_vld ? cmd : cmd_code_q;
    mr_d         = mr_q;
    if (is_mrst) mr_d[bank[1:0]] = pins.ADDRESS_PIN;

    // Highest-priority violation of this command cycle
    new_code = ERR_NONE;
    if (cmd_vld && !pins.CKE)                                    new_code = ERR_CKE;
    else if (!seq_ok || (is_mrst && bank[2]))                    new_code = ERR_SEQ;
    else if (cmd_vld && too_soon(cnt_mrd_q, T_MRD))              new_code = ERR_TMRD;
    else if (cmd_vld && too_soon(cnt_rfc_q, T_RFC))              new_code = ERR_TRFC;
    else if ((is_actv || is_arsr || is_mrst) && too_soon(cnt_rp_q, T_RP))
                                                                 new_code = ERR_TRP;
    else if (is_rdwr && !BANK_OPEN[bank])                        new_code = ERR_CLOSED;
    else if (is_actv && BANK_OPEN[bank])                         new_code = ERR_OPEN;
    else if (is_rdwr && rcd_early)                               new_code = ERR_TRCD;
    else if ((is_actv || is_rdwr) && state_q != S_DONE)          new_code = ERR_NOINIT;

    err_d      = err_q;
    err_code_d = err_code_q;
    if (!err_q && new_code != ERR_NONE) begin
      err_d      = 1'b1;
      err_code_d = new_code;
    end
  end

  ddr2_bank_tracker #(.T_RCD(T_RCD)) u_banks (
    .CLK_n     (CLK_n),
    .RST       (RST),
    .set_en    (is_actv),
    .clr_en    ((is_prch && !a10) || (is_rdwr && a10)),
    .clr_all   (is_prch && a10),
    .bank      (bank),
    .bank_open (BANK_OPEN),
    .rcd_early (rcd_early)
  );

  always_ff @(posedge CLK_n) begin
    if (!RST) begin
      state_q      <= S_CKE;
      cnt_mrd_q    <= '1;
      cnt_rp_q     <= '1;
      cnt_rfc_q    <= '1;
      cmd_strobe_q <= 1'b0;
      cmd_code_q   <= '0;
      mr_q         <= '{default: '0};
      err_q        <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_mrd_q    <= cnt_mrd_d;
      cnt_rp_q     <= cnt_rp_d;
      cnt_rfc_q    <= cnt_rfc_d;
      cmd_strobe_q <= cmd_strobe_d;
      cmd_code_q   <= cmd_code_d;
      mr_q         <= mr_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign CMD_STROBE = cmd_strobe_q;
  assign CMD_CODE   = cmd_code_q;
  assign MR0        = mr_q[0];
  assign MR1        = mr_q[1];
  assign MR2        = mr_q[2];
  assign MR3        = mr_q[3];
  assign INIT_DONE  = (state_q == S_DONE);
  assign ERROR      = err_q;
  assign ERR_CODE   = err_code_q;

endmodule
